// File: rtl/regfile_wb_queue_if.sv
// rtl/regfile_wb_queue_if.sv - producer handshakes, regfile/PC write port and status of the write-back queue
// Lookup ports exist only when REGFILE_WB_FWD_EN is defined.
interface regfile_wb_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          mem_valid;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic          pc_we;
  logic [DW-1:0] pc_wd;
  logic [15:0]   pend_mask;
  logic [CW-1:0] count;
`ifdef REGFILE_WB_FWD_EN
  logic [AW-1:0] fq_ra;
  logic          fq_hit;
  logic [DW-1:0] fq_data;
`endif

  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
`ifdef REGFILE_WB_FWD_EN
    input  fq_ra,
    output fq_hit, fq_data,
`endif
    output mem_ready, alu_ready, we3, wa3, wd3, pc_we, pc_wd, pend_mask, count
  );

  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
`ifdef REGFILE_WB_FWD_EN
    output fq_ra,
    input  fq_hit, fq_data,
`endif
    input  mem_ready, alu_ready, we3, wa3, wd3, pc_we, pc_wd, pend_mask, count
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order write-back FIFO feeding regfile port 3 and the PC (R15) write port
// REGFILE_WB_FWD_EN adds a combinational youngest-match lookup (fq_ra/fq_hit/fq_data).
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  regfile_wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] rd_q   [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, alu_slot;
  logic [CW-1:0] count_q, free;
  logic          push_mem, push_alu, pop;
  logic          we3_q, pc_we_q;
  logic [AW-1:0] wa3_q;
  logic [DW-1:0] wd3_q, pc_wd_q;
  logic [15:0]   pend;

  // Credit comes from the registered count only; a pop this cycle frees nothing yet.
  assign free          = CW'(DEPTH) - count_q;
  assign bus.mem_ready = ~flush & (free != '0);
  assign bus.alu_ready = ~flush & ((free >= CW'(2)) | ((free != '0) & ~bus.mem_valid));
  assign push_mem      = bus.mem_valid & bus.mem_ready;
  assign push_alu      = bus.alu_valid & bus.alu_ready;
  assign pop           = (count_q != '0);
  assign alu_slot      = wr_ptr + PW'(push_mem);

  always_ff @(posedge clk) begin
    if (push_mem) begin
      rd_q[wr_ptr]   <= bus.mem_rd;
      data_q[wr_ptr] <= bus.mem_data;
    end
    if (push_alu) begin
      rd_q[alu_slot]   <= bus.alu_rd;
      data_q[alu_slot] <= bus.alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
      pc_we_q <= 1'b0;
      pc_wd_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      we3_q   <= 1'b0;
      pc_we_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(push_mem) + PW'(push_alu);
      count_q <= count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (rd_q[rd_ptr] == AW'(15)) begin
          we3_q   <= 1'b0;
          pc_we_q <= 1'b1;
          pc_wd_q <= data_q[rd_ptr];
        end else begin
          we3_q   <= 1'b1;
          wa3_q   <= rd_q[rd_ptr];
          wd3_q   <= data_q[rd_ptr];
          pc_we_q <= 1'b0;
        end
      end else begin
        we3_q   <= 1'b0;
        pc_we_q <= 1'b0;
      end
    end
  end

  always_comb begin
    pend = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) pend[rd_q[rd_ptr + PW'(k)]] = 1'b1;
    end
    if (we3_q)   pend[wa3_q] = 1'b1;
    if (pc_we_q) pend[15]    = 1'b1;
  end

`ifdef REGFILE_WB_FWD_EN
  // Output stage is oldest, so it is checked first and any FIFO match overrides it.
  always_comb begin
    bus.fq_hit  = 1'b0;
    bus.fq_data = '0;
    if (we3_q && wa3_q == bus.fq_ra) begin
      bus.fq_hit  = 1'b1;
      bus.fq_data = wd3_q;
    end
    if (pc_we_q && bus.fq_ra == AW'(15)) begin
      bus.fq_hit  = 1'b1;
      bus.fq_data = pc_wd_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q && rd_q[rd_ptr + PW'(k)] == bus.fq_ra) begin
        bus.fq_hit  = 1'b1;
        bus.fq_data = data_q[rd_ptr + PW'(k)];
      end
    end
  end
`endif

  assign bus.we3       = we3_q;
  assign bus.wa3       = wa3_q;
  assign bus.wd3       = wd3_q;
  assign bus.pc_we     = pc_we_q;
  assign bus.pc_wd     = pc_wd_q;
  assign bus.pend_mask = pend;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - directed self-checking bench for regfile_wb_queue
module tb_regfile_wb_queue;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_queue_if #(.DEPTH(4), .AW(4), .DW(32)) q ();

  regfile_wb_queue #(.DEPTH(4), .AW(4), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (q)
  );

  logic [31:0] rf [16];
  logic [35:0] wlog [$];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (q.we3 === 1'b1) begin
      rf[q.wa3] <= q.wd3;
      wlog.push_back({q.wa3, q.wd3});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    q.mem_valid = 1'b0;
    q.alu_valid = 1'b0;
  endtask

  logic [35:0] exp_log [6];
  logic        exp_mr [4];
  logic        exp_ar [4];
  int          base;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    q.mem_valid = 1'b0; q.mem_rd = '0; q.mem_data = '0;
    q.alu_valid = 1'b0; q.alu_rd = '0; q.alu_data = '0;
`ifdef REGFILE_WB_FWD_EN
    q.fq_ra = '0;
`endif
    step();
    step();
    chk("rst_count", q.count, 0);
    chk("rst_we3", q.we3, 0);
    chk("rst_pc_we", q.pc_we, 0);
    chk("rst_wa3", q.wa3, 0);
    chk("rst_wd3", q.wd3, 0);
    chk("rst_pend", q.pend_mask, 0);
    rst_n = 1'b1;

    // 1: single ALU write, two-edge latency
    q.alu_valid = 1'b1; q.alu_rd = 4'd3; q.alu_data = 32'h11;
    chk("t1_alu_ready", q.alu_ready, 1);
    step();
    idle();
    chk("t1_count", q.count, 1);
    chk("t1_we3_early", q.we3, 0);
    chk("t1_pend_q", q.pend_mask, 16'h0008);
    step();
    chk("t1_we3", q.we3, 1);
    chk("t1_wa3", q.wa3, 3);
    chk("t1_wd3", q.wd3, 32'h11);
    chk("t1_pend_stage", q.pend_mask, 16'h0008);
    step();
    chk("t1_we3_off", q.we3, 0);
    chk("t1_rf3", rf[3], 32'h11);
    chk("t1_pend_clr", q.pend_mask, 0);

    // 2: same-cycle mem+alu, mem is older
    q.mem_valid = 1'b1; q.mem_rd = 4'd5; q.mem_data = 32'hAA;
    q.alu_valid = 1'b1; q.alu_rd = 4'd5; q.alu_data = 32'hBB;
    step();
    idle();
    chk("t2_count", q.count, 2);
    chk("t2_pend", q.pend_mask, 16'h0020);
    step();
    chk("t2_wd3_a", q.wd3, 32'hAA);
    step();
    chk("t2_wd3_b", q.wd3, 32'hBB);
    chk("t2_we3_b", q.we3, 1);
    step();
    chk("t2_rf5", rf[5], 32'hBB);

    // 3: both producers held valid for four cycles
    exp_mr = '{1'b1, 1'b1, 1'b1, 1'b1};
    exp_ar = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_log[0] = {4'd1,  32'h101};
    exp_log[1] = {4'd9,  32'h201};
    exp_log[2] = {4'd2,  32'h102};
    exp_log[3] = {4'd10, 32'h202};
    exp_log[4] = {4'd3,  32'h103};
    exp_log[5] = {4'd4,  32'h104};
    base = wlog.size();
    for (int c = 1; c <= 4; c++) begin
      q.mem_valid = 1'b1; q.mem_rd = 4'(c);     q.mem_data = 32'h100 + 32'(c);
      q.alu_valid = 1'b1; q.alu_rd = 4'(8 + c); q.alu_data = 32'h200 + 32'(c);
      #1;
      chk($sformatf("t3_mem_ready_c%0d", c), q.mem_ready, exp_mr[c-1]);
      chk($sformatf("t3_alu_ready_c%0d", c), q.alu_ready, exp_ar[c-1]);
      step();
    end
    idle();
    chk("t3_count_full", q.count, 3);
    for (int i = 0; i < 5; i++) step();
    chk("t3_nwrites", wlog.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < wlog.size()) chk($sformatf("t3_write%0d", i), wlog[base+i], exp_log[i]);
      else chk($sformatf("t3_write%0d_missing", i), 0, exp_log[i]);
    end

    // 4: R15 goes to the PC port
    q.alu_valid = 1'b1; q.alu_rd = 4'd15; q.alu_data = 32'h100;
    step();
    idle();
    chk("t4_pend_q", q.pend_mask, 16'h8000);
    step();
    chk("t4_pc_we", q.pc_we, 1);
    chk("t4_pc_wd", q.pc_wd, 32'h100);
    chk("t4_we3", q.we3, 0);
    chk("t4_pend_stage", q.pend_mask, 16'h8000);
    step();
    chk("t4_pc_we_off", q.pc_we, 0);
    chk("t4_pend_clr", q.pend_mask, 0);

    // 5: flush discards queued entries and the same-cycle push
    q.mem_valid = 1'b1; q.mem_rd = 4'd11; q.mem_data = 32'hD1;
    q.alu_valid = 1'b1; q.alu_rd = 4'd12; q.alu_data = 32'hD2;
    step();
    q.mem_rd = 4'd13; q.mem_data = 32'hD3;
    q.alu_rd = 4'd14; q.alu_data = 32'hD4;
    step();
    chk("t5_count3", q.count, 3);
    q.mem_valid = 1'b0;
    q.alu_rd = 4'd6; q.alu_data = 32'hEE;
    flush = 1'b1;
    #1;
    chk("t5_alu_ready_flush", q.alu_ready, 0);
    chk("t5_mem_ready_flush", q.mem_ready, 0);
    step();
    flush = 1'b0;
    idle();
    base = wlog.size();
    chk("t5_count", q.count, 0);
    chk("t5_we3", q.we3, 0);
    chk("t5_pc_we", q.pc_we, 0);
    chk("t5_pend", q.pend_mask, 0);
    for (int i = 0; i < 3; i++) step();
    chk("t5_no_writes", wlog.size() - base, 0);
    chk("t5_rf6", rf[6], 0);
    chk("t5_rf13", rf[13], 0);
    chk("t5_rf14", rf[14], 0);

`ifdef REGFILE_WB_FWD_EN
    // 6: youngest match wins
    q.mem_valid = 1'b1; q.mem_rd = 4'd7; q.mem_data = 32'h1;
    q.alu_valid = 1'b1; q.alu_rd = 4'd7; q.alu_data = 32'h2;
    step();
    idle();
    q.fq_ra = 4'd7;
    #1;
    chk("t6_hit", q.fq_hit, 1);
    chk("t6_data", q.fq_data, 32'h2);
    q.fq_ra = 4'd8;
    #1;
    chk("t6_miss_hit", q.fq_hit, 0);
    chk("t6_miss_data", q.fq_data, 0);
    q.fq_ra = 4'd7;
    step();
    chk("t6_hit_stage_q", q.fq_data, 32'h2);
    step();
    chk("t6_hit_stage", q.fq_data, 32'h2);
    step();
    chk("t6_drained", q.fq_hit, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
